zad2_mux: RTL and testbench
===========================

// Module: zad2_mux
//
// PURPOSE
//   Registered WIDTH-bit 2:1 selector.
//   - kont_sign=1 forwards operand a; kont_sign=0 forwards operand b.
//   - Result is captured into an output register one clock after a valid input.
//   - Used as a datapath steering stage between two 8-bit sources and one consumer.
//
// PARAMETERS
//   WIDTH  8  data width of a, b and out (legal range 1..64)
//
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   a          in   WIDTH  operand selected when kont_sign=1
//   b          in   WIDTH  operand selected when kont_sign=0
//   kont_sign  in   1      select control: 1 -> a, 0 -> b
//   in_valid   in   1      a/b/kont_sign qualify this cycle
//   out        out  WIDTH  registered selected operand
//   out_valid  out  1      out updated on the last rising edge
//   out_par    out  1      even parity of out (only when ZAD2_PARITY_EN defined)
//
// BEHAVIOUR
//   - Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
//   - Reset values: rst_n=0 immediately forces out=0, out_valid=0 and out_par=0,
//     independent of clk. Release is synchronous to the next rising clk edge.
//   - Capture: on a rising clk edge with in_valid=1, out <= kont_sign ? a : b and
//     out_valid <= 1. Latency is exactly 1 cycle.
//   - Hold: on a rising clk edge with in_valid=0, out holds its value and
//     out_valid <= 0. No bubble-fill or zeroing.
//   - Throughput: one new result per cycle. There is no backpressure and no ready
//     signal; the consumer must accept out whenever out_valid=1.
//   - Width rules: pure selection with no arithmetic. All WIDTH bits are passed
//     unchanged; no sign or zero extension.
//   - X/unknown on kont_sign while in_valid=1 is a protocol violation; the design
//     must not rely on its value.
//   - Reset mid-operation: an asserted rst_n discards any in-flight result.
//     The first in_valid=1 after release produces out_valid=1 one cycle later.
//   - Simultaneous select change and data change: the values sampled at the edge
//     apply. There is no memory of the previous select.
//   - Back-to-back: alternating kont_sign on consecutive valid cycles yields the
//     matching alternating sequence on out, one cycle delayed.
//
// CONFIGURATION
//   ZAD2_PARITY_EN
//     - Defined: port out_par is present and is registered alongside out
//       (out_par = ^(selected operand)). Reset value 0; holds when in_valid=0.
//     - Undefined: port out_par and its logic are omitted. All other behaviour
//       is identical.
//
// TESTING
//   1. Reset: rst_n=0 mid-cycle -> out=8'h00 and out_valid=0 immediately,
//      without waiting for a clk edge.
//   2. Select a: a=8'hFF, b=8'h00, kont_sign=1, in_valid=1 -> next edge
//      out=8'hFF, out_valid=1, out_par=0.
//   3. Select b: a=8'hFF, b=8'h00, kont_sign=0, in_valid=1 -> next edge
//      out=8'h00, out_valid=1.
//   4. Hold: after out=8'hFF, drive in_valid=0 with b=8'h5A, kont_sign=0 ->
//      out stays 8'hFF and out_valid=0.
//   5. Back-to-back: a=8'h3C, b=8'hC1, kont_sign toggling 1,0,1 each cycle ->
//      out = 3C, C1, 3C on successive edges; out_par = 0, 1, 0.
//   6. Reset mid-stream: assert rst_n during case 5 -> out=0 and out_valid=0
//      immediately; first valid input after release is reproduced one cycle later.

Source files
------------

// File: rtl/zad2_mux.sv
// Registered WIDTH-bit 2:1 selector: kont_sign=1 forwards a, kont_sign=0 forwards b, one cycle latency.
// Optional even-parity output out_par is built when ZAD2_PARITY_EN is defined.
module zad2_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kont_sign,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef ZAD2_PARITY_EN
  ,
  output logic             out_par
`endif
);

`ifdef ZAD2_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  logic [WIDTH-1:0] sel_p0;
  logic [WIDTH-1:0] out_p1;
  logic             vld_p1;

  assign sel_p0 = kont_sign ? a : b;

  // p0 -> p1: capture the selected operand; hold data when no valid input arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) out_p1 <= sel_p0;
    end
  end

`ifdef ZAD2_PARITY_EN
  logic par_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_p1 <= 1'b0;
    else if (in_valid) par_p1 <= even_par(sel_p0);
  end

  assign out_par = par_p1;
`endif

  assign out       = out_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_zad2_mux.sv
// Scoreboard bench for zad2_mux; parity checks are compiled in when ZAD2_PARITY_EN is defined.
module tb_zad2_mux;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kont_sign;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
`ifdef ZAD2_PARITY_EN
  logic             out_par;
`endif

  zad2_mux #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .kont_sign (kont_sign),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
`ifdef ZAD2_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Each entry is {parity, data} of a result the DUT still owes.
  logic [WIDTH:0]   sb[$];
  logic [WIDTH-1:0] model_out;
  logic             model_par;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1: drive one cycle of stimulus, then sample at the next posedge+1.
  task automatic cycle(input bit v, input bit k, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input string tag);
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   e;
    a = av;
    b = bv;
    kont_sign = k;
    in_valid = v;
    if (v) begin
      d = k ? av : bv;
      sb.push_back({^d, d});
    end
    @(posedge clk);
    #1;
    check({tag, "_vld"}, out_valid, v);
    if (out_valid) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = sb.pop_front();
        model_out = e[WIDTH-1:0];
        model_par = e[WIDTH];
        check({tag, "_out"}, out, model_out);
`ifdef ZAD2_PARITY_EN
        check({tag, "_par"}, out_par, model_par);
`endif
      end
    end else begin
      check({tag, "_hold"}, out, model_out);
`ifdef ZAD2_PARITY_EN
      check({tag, "_hold_par"}, out_par, model_par);
`endif
    end
  endtask

  // Called at posedge+1: assert reset mid-cycle, check the asynchronous clear, release mid-cycle.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_async_out"}, out, 0);
    check({tag, "_async_vld"}, out_valid, 0);
`ifdef ZAD2_PARITY_EN
    check({tag, "_async_par"}, out_par, 0);
`endif
    sb.delete();
    model_out = '0;
    model_par = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_held_out"}, out, 0);
    check({tag, "_held_vld"}, out_valid, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0;
    b = '0;
    kont_sign = 1'b0;
    in_valid = 1'b0;
    model_out = '0;
    model_par = 1'b0;

    @(posedge clk);
    #1;
    check("init_out", out, 0);
    check("init_vld", out_valid, 0);
`ifdef ZAD2_PARITY_EN
    check("init_par", out_par, 0);
`endif
    rst_n = 1'b1;

    cycle(1'b1, 1'b1, 8'hFF, 8'h00, "sel_a");
    cycle(1'b1, 1'b0, 8'hFF, 8'h00, "sel_b");
    cycle(1'b1, 1'b1, 8'hFF, 8'h00, "sel_a2");
    check("sel_a2_const", out, 8'hFF);
    cycle(1'b0, 1'b0, 8'hFF, 8'h5A, "hold1");
    check("hold1_const", out, 8'hFF);
    cycle(1'b0, 1'b1, 8'h12, 8'h5A, "hold2");

    do_reset("rst1");
    cycle(1'b1, 1'b0, 8'hA5, 8'h0F, "post_rst1");

    cycle(1'b1, 1'b1, 8'h3C, 8'hC1, "b2b_0");
    check("b2b_0_const", out, 8'h3C);
    cycle(1'b1, 1'b0, 8'h3C, 8'hC1, "b2b_1");
    check("b2b_1_const", out, 8'hC1);
`ifdef ZAD2_PARITY_EN
    check("b2b_1_par_const", out_par, 1);
`endif
    cycle(1'b1, 1'b1, 8'h3C, 8'hC1, "b2b_2");
    check("b2b_2_const", out, 8'h3C);

    // Reset lands while a valid C1 selection is waiting for its capture edge.
    cycle(1'b1, 1'b1, 8'h3C, 8'hC1, "mid_0");
    a = 8'h3C;
    b = 8'hC1;
    kont_sign = 1'b0;
    in_valid = 1'b1;
    do_reset("rst2");
    cycle(1'b1, 1'b0, 8'h3C, 8'h96, "post_rst2");
    check("post_rst2_const", out, 8'h96);

    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            WIDTH'($urandom), WIDTH'($urandom), "rand");
    end
    cycle(1'b0, 1'b0, 8'h00, 8'h00, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
